game_flow_controller: RTL and testbench
=======================================

// Module: game_flow_controller
// PURPOSE
//  Game-level sequencer downstream of TopModule_GameLogic. Consumes pacman_is_dead and the
//  per-pellet eat strobe; tracks lives and remaining pellets; runs IDLE/READY/PLAY/DEATH/
//  LEVEL_CLEAR/GAME_OVER. Drives game_rst into the game-logic rst and a freeze enable that
//  stalls sprite movement outside PLAY.
// PARAMETERS
//  LIVES_INIT    3     lives loaded at reset and at new game (1..3)
//  TOTAL_FOOD    310   pellets per level; dots_left reload value
//  DOT_W         13    width of dots_left (holds up to 8191)
//  READY_TICKS   120   tick_en pulses spent in READY before PLAY (>=1)
//  DEATH_TICKS   90    tick_en pulses spent in DEATH (>=1)
//  CLEAR_TICKS   150   tick_en pulses spent in LEVEL_CLEAR (>=1)
//  TMR_W         8     timer width; every *_TICKS must be < 2**TMR_W
// PORTS
//  clk             in   1      system clock
//  rst             in   1      synchronous, active-high reset
//  tick_en         in   1      1-cycle frame strobe; all state timers count on it
//  start_btn       in   1      raw level from start button (already synchronised)
//  pacman_is_dead  in   1      level from game logic; may stay high several cycles
//  food_eaten      in   1      1-cycle pulse per pellet eaten (game logic is_food)
//  game_rst        out  1      1-cycle pulse; re-seeds sprite positions/score
//  freeze          out  1      1 = sprites must not move
//  lives           out  2      lives remaining
//  dots_left       out  DOT_W  pellets remaining this level
//  level           out  4      level number, saturates at 15
//  state           out  3      encoded FSM state (shared package)
// BEHAVIOUR
//  Clock/reset: one clock, clk; rst synchronous active-high, beats every other input.
//  Reset values: state=IDLE, lives=LIVES_INIT, dots_left=TOTAL_FOOD, level=1, timer=0,
//   game_rst=1 (asserted on the cycle reset is applied, low once rst drops unless
//   re-triggered), freeze=1.
//  freeze = (state != PLAY), combinational from the state register.
//  Edge detect: start_rise = start_btn & ~start_q; dead_rise = pacman_is_dead & ~dead_q;
//   start_q/dead_q are cleared by rst.
//  State transitions (registered, 1-cycle latency from qualifying input):
//   IDLE        start_rise -> READY; game_rst=1; lives=LIVES_INIT; dots_left=TOTAL_FOOD; level=1.
//   READY       timer counts tick_en; when it reaches READY_TICKS-1 on a tick -> PLAY, timer=0.
//   PLAY        dead_rise -> DEATH; lives decrements (0 never underflows).
//               else food_eaten & dots_left==1 -> LEVEL_CLEAR, dots_left=0.
//               else food_eaten -> dots_left-1.
//   DEATH       after DEATH_TICKS ticks: lives==0 -> GAME_OVER, else -> READY + game_rst
//               (dots_left retained).
//   LEVEL_CLEAR after CLEAR_TICKS ticks -> READY + game_rst; dots_left=TOTAL_FOOD;
//               level+1, saturating at 15.
//   GAME_OVER   start_rise -> behaves as IDLE start_rise.
//  game_rst: exactly 1 cycle, on the cycle the state register becomes READY.
//  Priorities: dead_rise beats food_eaten in the same cycle (pellet not counted).
//   food_eaten/dead_rise outside PLAY are ignored. start_rise outside IDLE/GAME_OVER ignored.
//   pacman_is_dead held high across PLAY entry: no edge, so no death.
//  Timer: cleared on every state change; a tick on the state-change cycle is not counted.
//  Lives 3 -> three deaths -> GAME_OVER; the last death shows lives=0.
//  Unused state encodings go to IDLE on the next clk.
// STRUCTURE
//  Package game_pkg: state encodings ST_IDLE=0, ST_READY=1, ST_PLAY=2, ST_DEATH=3,
//   ST_CLEAR=4, ST_OVER=5; the LIVES_INIT and TOTAL_FOOD defaults.
//  One sub-module: edge_detect (1-bit registered rising-edge pulse, sync rst); two
//   instances, for start_btn and pacman_is_dead.
//  FSM, timer, lives, dots and level counters all live inline in this module.
// TESTING
//  1 rst 2 cycles, then start_btn high -> next cycle state=READY, game_rst=1 for 1 cycle,
//    lives=3, dots_left=310, freeze=1.
//  2 READY_TICKS=4: 4 tick_en pulses -> state=PLAY on the clk after the 4th; freeze=0.
//  3 PLAY, dots_left=2: two food_eaten pulses -> 1, then 0 with state=LEVEL_CLEAR; after
//    CLEAR_TICKS -> READY, level=2, dots_left=310, game_rst pulse.
//  4 PLAY, pacman_is_dead and food_eaten in the same cycle -> DEATH, lives 3->2,
//    dots_left unchanged; dead held high 5 cycles decrements only once.
//  5 Three deaths -> GAME_OVER, lives=0, freeze=1; start_btn rise -> READY, lives=3.
//  6 rst mid-DEATH (timer=40) -> next cycle IDLE, timer=0, lives=3, dots_left=310.

Source files
------------

// File: rtl/game_pkg.sv
// Shared state encodings and game-level defaults for the game flow controller.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DEATH = 3'd3,
        ST_CLEAR = 3'd4,
        ST_OVER  = 3'd5
    } state_e;

    localparam int LIVES_INIT_DEF = 3;
    localparam int TOTAL_FOOD_DEF = 310;

endpackage

// File: rtl/game_flow_controller_edge_detect.sv
// One-bit rising-edge detector: pulse is high while the input is high and was low last cycle.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig_i;
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/game_flow_controller.sv
// Game-level sequencer: tracks lives, pellets and level, and gates sprite motion outside PLAY.
module game_flow_controller
    import game_pkg::*;
#(
    parameter int LIVES_INIT  = LIVES_INIT_DEF,
    parameter int TOTAL_FOOD  = TOTAL_FOOD_DEF,
    parameter int DOT_W       = 13,
    parameter int READY_TICKS = 120,
    parameter int DEATH_TICKS = 90,
    parameter int CLEAR_TICKS = 150,
    parameter int TMR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_en,
    input  logic             start_btn,
    input  logic             pacman_is_dead,
    input  logic             food_eaten,
    output logic             game_rst,
    output logic             freeze,
    output logic [1:0]       lives,
    output logic [DOT_W-1:0] dots_left,
    output logic [3:0]       level,
    output logic [2:0]       state
);

    localparam logic [TMR_W-1:0] READY_LAST = TMR_W'(READY_TICKS - 1);
    localparam logic [TMR_W-1:0] DEATH_LAST = TMR_W'(DEATH_TICKS - 1);
    localparam logic [TMR_W-1:0] CLEAR_LAST = TMR_W'(CLEAR_TICKS - 1);
    localparam logic [1:0]       LIVES_RST  = 2'(LIVES_INIT);
    localparam logic [DOT_W-1:0] FOOD_RST   = DOT_W'(TOTAL_FOOD);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       lives_q, lives_d;
    logic [DOT_W-1:0] dots_q, dots_d;
    logic [3:0]       level_q, level_d;
    logic             game_rst_q, game_rst_d;
    logic             start_rise, dead_rise;

    edge_detect u_start_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (start_btn),
        .rise_o (start_rise)
    );

    edge_detect u_dead_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (pacman_is_dead),
        .rise_o (dead_rise)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        lives_d = lives_q;
        dots_d  = dots_q;
        level_d = level_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    state_d = ST_READY;
                    lives_d = LIVES_RST;
                    dots_d  = FOOD_RST;
                    level_d = 4'd1;
                end
            end
            ST_READY: begin
                if (tick_en) begin
                    if (timer_q == READY_LAST) state_d = ST_PLAY;
                    else                       timer_d = timer_q + 1'b1;
                end
            end
            ST_PLAY: begin
                // A death swallows any pellet eaten on the same cycle.
                if (dead_rise) begin
                    state_d = ST_DEATH;
                    lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                end else if (food_eaten) begin
                    if (dots_q == DOT_W'(1)) begin
                        state_d = ST_CLEAR;
                        dots_d  = '0;
                    end else if (dots_q != '0) begin
                        dots_d  = dots_q - DOT_W'(1);
                    end
                end
            end
            ST_DEATH: begin
                if (tick_en) begin
                    if (timer_q == DEATH_LAST)
                        state_d = (lives_q == 2'd0) ? ST_OVER : ST_READY;
                    else
                        timer_d = timer_q + 1'b1;
                end
            end
            ST_CLEAR: begin
                if (tick_en) begin
                    if (timer_q == CLEAR_LAST) begin
                        state_d = ST_READY;
                        dots_d  = FOOD_RST;
                        level_d = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every state starts its timer fresh; a tick on the change cycle is dropped.
        if (state_d != state_q) timer_d = '0;

        game_rst_d = (state_d == ST_READY) && (state_q != ST_READY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            lives_q    <= LIVES_RST;
            dots_q     <= FOOD_RST;
            level_q    <= 4'd1;
            game_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            lives_q    <= lives_d;
            dots_q     <= dots_d;
            level_q    <= level_d;
            game_rst_q <= game_rst_d;
        end
    end

    assign game_rst  = game_rst_q;
    assign freeze    = (state_q != ST_PLAY);
    assign lives     = lives_q;
    assign dots_left = dots_q;
    assign level     = level_q;
    assign state     = state_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Self-checking bench: vector table for bring-up plus hand sequences for death/clear/reset corners.
module tb_game_flow_controller;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1, tick_en = 1'b0, start_btn = 1'b0;
    logic        pacman_is_dead = 1'b0, food_eaten = 1'b0;
    logic        game_rst, freeze;
    logic [1:0]  lives;
    logic [12:0] dots_left;
    logic [3:0]  level;
    logic [2:0]  state;

    game_flow_controller #(
        .LIVES_INIT(3), .TOTAL_FOOD(310), .DOT_W(13),
        .READY_TICKS(4), .DEATH_TICKS(50), .CLEAR_TICKS(5), .TMR_W(8)
    ) dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .start_btn(start_btn),
        .pacman_is_dead(pacman_is_dead), .food_eaten(food_eaten),
        .game_rst(game_rst), .freeze(freeze), .lives(lives),
        .dots_left(dots_left), .level(level), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [1:0]  lv;
        logic [12:0] dots;
        logic [3:0]  lvl;
        logic        grst;
        logic        frz;
    } out_t;

    typedef struct {
        logic  r, s, d, f, t;
        out_t  e;
        string nm;
    } vec_t;

    out_t  sb_q[$];
    string nm_q[$];
    int    checks = 0;
    int    errors = 0;

    logic [2:0]  e_st;
    logic [1:0]  e_lv;
    logic [12:0] e_dots;
    logic [3:0]  e_lvl;
    logic        e_grst;

    function automatic out_t mk(input logic [2:0] st, input logic [1:0] lv,
                                input logic [12:0] dots, input logic [3:0] lvl,
                                input logic grst);
        out_t o;
        o.st = st; o.lv = lv; o.dots = dots; o.lvl = lvl; o.grst = grst;
        o.frz = (st != ST_PLAY);
        return o;
    endfunction

    task automatic compare_out();
        out_t  exp, got;
        string n;
        exp = sb_q.pop_front();
        n   = nm_q.pop_front();
        got = '{st: state, lv: lives, dots: dots_left, lvl: level, grst: game_rst, frz: freeze};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d lives=%0d dots=%0d lvl=%0d grst=%b frz=%b, exp st=%0d lives=%0d dots=%0d lvl=%0d grst=%b frz=%b",
                     n, got.st, got.lv, got.dots, got.lvl, got.grst, got.frz,
                     exp.st, exp.lv, exp.dots, exp.lvl, exp.grst, exp.frz);
        end
    endtask

    task automatic apply(input logic r, s, d, f, t, input out_t e, input string nm);
        @(negedge clk);
        rst = r; start_btn = s; pacman_is_dead = d; food_eaten = f; tick_en = t;
        sb_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic stp(input logic r, s, d, f, t, input string nm);
        apply(r, s, d, f, t, mk(e_st, e_lv, e_dots, e_lvl, e_grst), nm);
        e_grst = 1'b0;
    endtask

    task automatic hold(input int n, input logic d, input string nm);
        for (int i = 0; i < n; i++) stp(1'b0, 1'b0, d, 1'b0, 1'b1, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl[13];
        tbl[0]  = '{1,0,0,0,0, mk(ST_IDLE,  3, 310, 1, 1), "reset1"};
        tbl[1]  = '{1,1,0,0,1, mk(ST_IDLE,  3, 310, 1, 1), "reset2"};
        tbl[2]  = '{0,0,0,0,0, mk(ST_IDLE,  3, 310, 1, 0), "idle"};
        tbl[3]  = '{0,1,0,0,0, mk(ST_READY, 3, 310, 1, 1), "start"};
        tbl[4]  = '{0,1,0,0,1, mk(ST_READY, 3, 310, 1, 0), "ready_t1"};
        tbl[5]  = '{0,0,0,0,0, mk(ST_READY, 3, 310, 1, 0), "ready_idle"};
        tbl[6]  = '{0,0,0,0,1, mk(ST_READY, 3, 310, 1, 0), "ready_t2"};
        tbl[7]  = '{0,0,0,0,1, mk(ST_READY, 3, 310, 1, 0), "ready_t3"};
        tbl[8]  = '{0,0,0,0,1, mk(ST_PLAY,  3, 310, 1, 0), "ready_t4_play"};
        tbl[9]  = '{0,1,0,0,0, mk(ST_PLAY,  3, 310, 1, 0), "start_in_play"};
        tbl[10] = '{0,0,0,1,0, mk(ST_PLAY,  3, 309, 1, 0), "eat1"};
        tbl[11] = '{0,0,0,1,1, mk(ST_PLAY,  3, 308, 1, 0), "eat2"};
        tbl[12] = '{0,0,1,1,0, mk(ST_DEATH, 2, 308, 1, 0), "dead_and_food"};
        for (int i = 0; i < 13; i++)
            apply(tbl[i].r, tbl[i].s, tbl[i].d, tbl[i].f, tbl[i].t, tbl[i].e, tbl[i].nm);

        e_st = ST_DEATH; e_lv = 2; e_dots = 308; e_lvl = 1; e_grst = 0;

        // Death with pacman_is_dead held high through DEATH, READY and into PLAY.
        hold(49, 1'b1, "death1_wait");
        e_st = ST_READY; e_grst = 1'b1;
        stp(0, 0, 1, 0, 1, "death1_to_ready");
        hold(3, 1'b1, "ready_held_dead");
        e_st = ST_PLAY;
        stp(0, 0, 1, 0, 1, "play_held_dead");
        for (int i = 0; i < 3; i++) stp(0, 0, 1, 1'b0, 0, "held_dead_no_edge");
        stp(0, 0, 0, 0, 0, "dead_low");
        e_st = ST_DEATH; e_lv = 1;
        stp(0, 0, 1, 0, 0, "death2");
        hold(49, 1'b0, "death2_wait");
        e_st = ST_READY; e_grst = 1'b1;
        stp(0, 0, 0, 0, 1, "death2_to_ready");
        hold(3, 1'b0, "ready2");
        e_st = ST_PLAY;
        stp(0, 0, 0, 0, 1, "play2");

        // Eat down to the last pellet and clear the level.
        while (e_dots > 2) begin
            e_dots = e_dots - 1;
            stp(0, 0, 0, 1, 0, "eat_down");
        end
        e_dots = 1;
        stp(0, 0, 0, 1, 0, "eat_to_1");
        stp(0, 0, 0, 0, 1, "no_food_tick");
        e_st = ST_CLEAR; e_dots = 0;
        stp(0, 0, 0, 1, 0, "eat_last_clear");
        stp(0, 0, 1, 1, 0, "dead_food_in_clear");
        hold(4, 1'b0, "clear_wait");
        e_st = ST_READY; e_dots = 310; e_lvl = 2; e_grst = 1'b1;
        stp(0, 0, 0, 0, 1, "clear_to_ready");
        hold(3, 1'b0, "ready3");
        e_st = ST_PLAY;
        stp(0, 0, 0, 0, 1, "play3");

        // Final death runs out of lives.
        e_st = ST_DEATH; e_lv = 0;
        stp(0, 0, 1, 0, 0, "death3");
        hold(49, 1'b0, "death3_wait");
        e_st = ST_OVER;
        stp(0, 0, 0, 0, 1, "game_over");
        stp(0, 0, 1, 1, 1, "over_ignores_inputs");
        e_st = ST_READY; e_lv = 3; e_dots = 310; e_lvl = 1; e_grst = 1'b1;
        stp(0, 1, 0, 0, 0, "restart");
        hold(3, 1'b0, "ready4");
        e_st = ST_PLAY;
        stp(0, 0, 0, 0, 1, "play4");

        // Reset in the middle of DEATH, then confirm the timer restarts from zero.
        e_st = ST_DEATH; e_lv = 2;
        stp(0, 0, 1, 0, 0, "death4");
        hold(40, 1'b0, "death4_wait");
        e_st = ST_IDLE; e_lv = 3; e_dots = 310; e_lvl = 1; e_grst = 1'b1;
        stp(1, 0, 0, 0, 1, "rst_mid_death");
        e_grst = 1'b1;
        stp(1, 1, 0, 0, 0, "rst_beats_start");
        stp(0, 0, 0, 0, 0, "idle_after_rst");
        e_st = ST_READY; e_grst = 1'b1;
        stp(0, 1, 0, 0, 0, "start_after_rst");
        hold(3, 1'b0, "ready5");
        e_st = ST_PLAY;
        stp(0, 0, 0, 0, 1, "play5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
